// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, SPI mode encodings
// and the bit positions of CPOL/CPHA inside the 2-bit mode word.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator. A down-counter is reloaded from div_i while
// disabled, and counts down while enabled; terminal count (zero) raises
// tick_o for one cycle and reloads, so ticks are div_i+1 cycles apart.
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Next count and terminal-count tick
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = div_i;
        end else if (cnt_q == '0) begin
            tick_o = 1'b1;
            cnt_d  = div_i;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one word per transfer, all four SPI modes,
// MSB/LSB-first, programmable SCK rate and one-hot active-low selects.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for start, sck = latched CPOL, mosi low
//   ST_SETUP | select asserted, one half-period before first SCK edge
//   ST_XFER  | 2*DATA_W half-periods of SCK toggling
//   ST_HOLD  | one half-period with sck idle before releasing select
//   ST_DONE  | single cycle: data_out updated, done pulsed
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int HC_W = $clog2(2 * DATA_W);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [CS_W-1:0]   cs_q, cs_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic              sck_q, sck_d, mosi_q, mosi_d;
    logic              tick, lead, trail, sample, shift;

    assign busy     = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
    assign done     = (state_q == ST_DONE);
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign data_out = dout_q;

    // The divider is reloaded from the live input while idle so the first
    // SETUP half-period already uses the value latched with start.
    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (busy),
        .div_i  ((state_q == ST_IDLE) ? clk_div : div_q),
        .tick_o (tick)
    );

    // Active-low select decode; out-of-range indices select nothing
    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (busy && (int'(cs_q) == i)) cs_n[i] = 1'b0;
        end
    end

    // Next-state, SCK edge generation and shift/sample datapath
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cs_d    = cs_q;
        div_d   = div_q;
        hc_d    = hc_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        lead    = 1'b0;
        trail   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sck_d  = cpol_q;
                mosi_d = 1'b0;
                if (start && !abort) begin
                    state_d = ST_SETUP;
                    cs_d    = cs_sel;
                    div_d   = clk_div;
                    cpol_d  = mode[CPOL_BIT];
                    cpha_d  = mode[CPHA_BIT];
                    lsb_d   = lsb_first;
                    sck_d   = mode[CPOL_BIT];
                    rx_d    = '0;
                    tx_d    = data_in;
                    // CPHA=0 needs the first bit valid before the first edge
                    if (!mode[CPHA_BIT]) begin
                        mosi_d = lsb_first ? data_in[0] : data_in[DATA_W-1];
                        tx_d   = lsb_first ? (data_in >> 1) : (data_in << 1);
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_XFER;
                    hc_d    = HC_LAST;
                    lead    = 1'b1;
                end
            end
            ST_XFER: begin
                // Odd remaining count means the next edge returns SCK to CPOL
                if (tick) begin
                    if (hc_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        hc_d  = hc_q - 1'b1;
                        trail = hc_q[0];
                        lead  = !hc_q[0];
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_DONE;
                    dout_d  = rx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                mosi_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (lead || trail) sck_d = ~sck_q;

        sample = cpha_q ? trail : lead;
        shift  = cpha_q ? lead  : trail;

        if (sample) begin
            rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
        end
        if (shift) begin
            mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        end

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            sck_d   = cpol_q;
            mosi_d  = 1'b0;
            dout_d  = dout_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cs_q    <= '0;
            div_q   <= '0;
            hc_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cs_q    <= cs_d;
            div_q   <= div_d;
            hc_q    <= hc_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: a table of transfers run against a
// behavioural slave, plus hand-written abort and mid-transfer reset cases.
// A second instance with NUM_CS=5 shares all stimulus so out-of-range
// selects can be exercised.
module tb_spi_master_param;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] data_in = '0;
    logic [1:0]  cs_sel = '0;
    logic [2:0]  cs_sel5 = '0;
    logic [1:0]  mode = '0;
    logic        lsb_first = 1'b0;
    logic [7:0]  clk_div = '0;
    logic        miso = 1'b0;
    logic [31:0] data_out, data_out5;
    logic        busy, done, mosi, sck;
    logic        busy5, done5, mosi5, sck5;
    logic [3:0]  cs_n;
    logic [4:0]  cs_n5;

    int nvec  = 0;
    int nfail = 0;
    logic [31:0] last_dout = '0;

    typedef struct {
        logic [1:0]  mode;
        logic        lsb;
        logic [7:0]  div;
        logic [31:0] din;
        logic [31:0] slv;
        logic [1:0]  cs;
        logic [2:0]  cs5;
        logic [3:0]  exp_csn;
        logic [4:0]  exp_csn5;
        int          exp_lat;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[6];
    vec_t vr;

    spi_master_param #(.DATA_W(32), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .data_in(data_in),
        .cs_sel(cs_sel), .mode(mode), .lsb_first(lsb_first), .clk_div(clk_div),
        .data_out(data_out), .busy(busy), .done(done), .miso(miso),
        .mosi(mosi), .sck(sck), .cs_n(cs_n)
    );

    spi_master_param #(.DATA_W(32), .NUM_CS(5), .DIV_W(8)) dut5 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .data_in(data_in),
        .cs_sel(cs_sel5), .mode(mode), .lsb_first(lsb_first), .clk_div(clk_div),
        .data_out(data_out5), .busy(busy5), .done(done5), .miso(miso),
        .mosi(mosi5), .sck(sck5), .cs_n(cs_n5)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sbit(input logic [31:0] w, input logic lsb, input int i);
        if (i > 31) return 1'b0;
        return lsb ? w[i] : w[31-i];
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        int   lat = 0, busy_cnt = 0, cs_bad = 0, cs5_bad = 0, twin_bad = 0;
        int   idx = 0, cnt = 0;
        logic [31:0] cap = '0;
        logic prev, lead, cpol, cpha;
        logic setup_sck = 1'bx, setup_busy = 1'bx;
        cpol = v.mode[CPOL_BIT];
        cpha = v.mode[CPHA_BIT];
        @(posedge clk); #1;
        data_in = v.din; mode = v.mode; lsb_first = v.lsb; clk_div = v.div;
        cs_sel = v.cs; cs_sel5 = v.cs5; start = 1'b1;
        miso = cpha ? 1'b0 : sbit(v.slv, v.lsb, 0);
        prev = sck;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = 1'b0;
                data_in = ~v.din; mode = ~v.mode; lsb_first = ~v.lsb;
                clk_div = v.div + 8'd7; cs_sel = v.cs + 2'd1; cs_sel5 = 3'd0;
                setup_sck = sck; setup_busy = busy;
            end else if (sck !== prev) begin
                lead = (sck !== cpol);
                if (lead == cpha) begin
                    if (cpha) begin
                        miso = sbit(v.slv, v.lsb, idx);
                        idx++;
                    end else begin
                        idx++;
                        miso = sbit(v.slv, v.lsb, idx);
                    end
                end else begin
                    cap = v.lsb ? {mosi, cap[31:1]} : {cap[30:0], mosi};
                    cnt++;
                end
            end
            prev = sck;
            if (busy) begin
                busy_cnt++;
                if (cs_n !== v.exp_csn) cs_bad++;
                if (cs_n5 !== v.exp_csn5) cs5_bad++;
            end
            if ({done5, busy5, sck5, mosi5} !== {done, busy, sck, mosi}) twin_bad++;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, "_setup_busy"}, 64'(setup_busy), 64'd1);
        chk({tag, "_setup_sck"}, 64'(setup_sck), 64'(cpol));
        chk({tag, "_data_out"}, 64'(data_out), 64'(v.exp_dout));
        chk({tag, "_data_out_ncs5"}, 64'(data_out5), 64'(v.exp_dout));
        chk({tag, "_mosi_word"}, 64'(cap), 64'(v.din));
        chk({tag, "_mosi_bits"}, 64'(cnt), 64'd32);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_lat - 1));
        chk({tag, "_cs_n_bad_cycles"}, 64'(cs_bad), 64'd0);
        chk({tag, "_cs_n5_bad_cycles"}, 64'(cs5_bad), 64'd0);
        chk({tag, "_twin_bad_cycles"}, 64'(twin_bad), 64'd0);
        chk({tag, "_done_cycle_busy_csn"}, {59'd0, busy, cs_n}, {59'd0, 1'b0, 4'hF});
        @(posedge clk); #1;
        chk({tag, "_after_done"}, {60'd0, done, busy, sck, mosi}, {60'd0, 1'b0, 1'b0, cpol, 1'b0});
        chk({tag, "_after_csn"}, 64'(cs_n), 64'hF);
        last_dout = v.exp_dout;
    endtask

    initial begin
        int bad;
        vecs[0] = '{MODE0, 1'b0, 8'd0, 32'h87654321, 32'h88885678, 2'd2, 3'd2, 4'b1011, 5'b11011,  67, 32'h88885678};
        vecs[1] = '{MODE1, 1'b0, 8'd0, 32'hFEDCBA98, 32'h56781234, 2'd0, 3'd0, 4'b1110, 5'b11110,  67, 32'h56781234};
        vecs[2] = '{MODE2, 1'b0, 8'd1, 32'hFEDCBA98, 32'h56781234, 2'd1, 3'd5, 4'b1101, 5'b11111, 133, 32'h56781234};
        vecs[3] = '{MODE3, 1'b0, 8'd0, 32'hFEDCBA98, 32'h56781234, 2'd3, 3'd4, 4'b0111, 5'b01111,  67, 32'h56781234};
        vecs[4] = '{MODE0, 1'b1, 8'd3, 32'h00000001, 32'h0F0FA5A5, 2'd2, 3'd5, 4'b1011, 5'b11111, 265, 32'h0F0FA5A5};
        vecs[5] = '{MODE3, 1'b1, 8'd2, 32'hC3C30001, 32'h1234ABCD, 2'd1, 3'd7, 4'b1101, 5'b11111, 199, 32'h1234ABCD};
        vr      = '{MODE3, 1'b0, 8'd0, 32'hA5A55A5A, 32'h0BADF00D, 2'd0, 3'd1, 4'b1110, 5'b11101,  67, 32'h0BADF00D};

        // Power-on reset values
        #1 rst = 1'b1;
        #1;
        chk("reset_outputs", {59'd0, busy, done, sck, mosi, 1'b0}, 64'd0);
        chk("reset_cs_n", 64'(cs_n), 64'hF);
        chk("reset_data_out", 64'(data_out), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Abort at bit 10 with a stray start pulsed while busy
        @(posedge clk); #1;
        data_in = 32'h12345678; mode = MODE0; lsb_first = 1'b0; clk_div = 8'd0;
        cs_sel = 2'd2; cs_sel5 = 3'd2; start = 1'b1;
        bad = 0;
        for (int n = 1; n <= 22; n++) begin
            @(posedge clk); #1;
            if (!busy) bad++;
            if (n == 1) start = 1'b0;
            if (n == 10) begin start = 1'b1; data_in = '0; cs_sel = 2'd1; end
            if (n == 11) begin
                start = 1'b0;
                chk("abort_stray_start_cs_n", 64'(cs_n), 64'b1011);
            end
            if (n == 22) abort = 1'b1;
        end
        chk("abort_busy_before", 64'(bad), 64'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_next_cycle", {60'd0, busy, done, sck, mosi}, 64'd0);
        chk("abort_cs_n", 64'(cs_n), 64'hF);
        chk("abort_data_out", 64'(data_out), 64'(last_dout));
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (done || busy || done5) bad++;
        end
        chk("abort_no_done_later", 64'(bad), 64'd0);
        chk("abort_data_out_later", 64'(data_out), 64'(last_dout));

        // Asynchronous reset in the middle of a mode-3 transfer
        @(posedge clk); #1;
        data_in = 32'hFFFF0000; mode = MODE3; lsb_first = 1'b0; clk_div = 8'd0;
        cs_sel = 2'd1; cs_sel5 = 3'd1; start = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
        end
        chk("rst_pre_sck_high", 64'(sck), 64'd1);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {59'd0, busy, done, sck, mosi, busy5}, 64'd0);
        chk("rst_mid_cs_n", {59'd0, cs_n5}, {59'd0, 5'h1F});
        chk("rst_mid_cs_n4", 64'(cs_n), 64'hF);
        chk("rst_mid_data_out", 64'(data_out), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_idle_sck_cpol0", 64'(sck), 64'd0);
        last_dout = '0;
        run_vec("post_rst", vr);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
